// File: rtl/sram_march_tester.sv
// March-style self-test engine for the 256Kx16 SRAM controller port: write pattern, read back, compare.
// Optional build macro SRAM_TEST_LFSR_EN selects an LFSR pattern instead of addr ^ seed.
module sram_march_tester #(
   parameter logic [17:0] ADDR_LO = 18'h00000,
   parameter logic [17:0] ADDR_HI = 18'h3FFFF,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] seed,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [15:0] err_count,
   output logic [17:0] first_err_addr,
   output logic        mem,
   output logic        rw,
   output logic [17:0] addr,
   output logic [15:0] data_f2s,
   input  logic        ready,
   input  logic [15:0] data_s2f_r
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      StIdle, StWrIssue, StWrWait, StRdIssue, StRdWait, StCheck, StDone
   } state_e;

   state_e        state_q, state_d;
   logic [17:0]   cur_addr_q, cur_addr_d;
   logic [15:0]   seed_q, seed_d;
   logic [15:0]   err_q, err_d;
   logic [17:0]   first_q, first_d;
   logic          timeout_q, timeout_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          mem_q, mem_d;
   logic          rw_q, rw_d;
   logic [17:0]   addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic [15:0]   pattern;
   logic          wait_ready, wait_tmo, last;

   // The first wait cycle is ignored: the controller drops ready only after accepting.
   assign wait_ready = (tcnt_q != '0) && ready;
   assign wait_tmo   = !wait_ready && (tcnt_q == TW'(TIMEOUT - 1));
   assign last       = (cur_addr_q == ADDR_HI);

`ifdef SRAM_TEST_LFSR_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16,14,13,11; a zero seed would lock up, so it is substituted.
   always_comb begin
      lfsr_d = lfsr_q;
      if ((state_q == StIdle || state_q == StDone) && start) begin
         lfsr_d = (seed == '0) ? 16'hACE1 : seed;
      end else if (state_q == StWrWait && wait_ready && last) begin
         lfsr_d = (seed_q == '0) ? 16'hACE1 : seed_q;
      end else if ((state_q == StWrWait && wait_ready) || state_q == StCheck) begin
         lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lfsr_q <= '0;
      else        lfsr_q <= lfsr_d;
   end

   assign pattern = lfsr_q;
`else
   assign pattern = cur_addr_q[15:0] ^ seed_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StDone: if (start) state_d = StWrIssue;
         StWrIssue:      if (ready) state_d = StWrWait;
         StWrWait: begin
            if (wait_ready)    state_d = last ? StRdIssue : StWrIssue;
            else if (wait_tmo) state_d = StDone;
         end
         StRdIssue:      if (ready) state_d = StRdWait;
         StRdWait: begin
            if (wait_ready)    state_d = StCheck;
            else if (wait_tmo) state_d = StDone;
         end
         StCheck:        state_d = last ? StDone : StRdIssue;
         default:        state_d = StIdle;
      endcase
   end

   always_comb begin
      cur_addr_d = cur_addr_q;
      seed_d     = seed_q;
      err_d      = err_q;
      first_d    = first_q;
      timeout_d  = timeout_q;
      tcnt_d     = tcnt_q;
      mem_d      = 1'b0;
      rw_d       = rw_q;
      addr_d     = addr_q;
      data_d     = data_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               seed_d     = seed;
               err_d      = '0;
               first_d    = '0;
               timeout_d  = 1'b0;
               cur_addr_d = ADDR_LO;
            end
         end
         StWrIssue: begin
            if (ready) begin
               mem_d  = 1'b1;
               rw_d   = 1'b0;
               addr_d = cur_addr_q;
               data_d = pattern;
               tcnt_d = '0;
            end
         end
         StWrWait: begin
            tcnt_d = tcnt_q + 1'b1;
            if (wait_ready) begin
               cur_addr_d = last ? ADDR_LO : cur_addr_q + 18'd1;
            end else if (wait_tmo) begin
               timeout_d = 1'b1;
            end
         end
         StRdIssue: begin
            if (ready) begin
               mem_d  = 1'b1;
               rw_d   = 1'b1;
               addr_d = cur_addr_q;
               tcnt_d = '0;
            end
         end
         StRdWait: begin
            tcnt_d = tcnt_q + 1'b1;
            if (wait_tmo) timeout_d = 1'b1;
         end
         StCheck: begin
            if (data_s2f_r != pattern) begin
               if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
               if (err_q == '0)       first_d = cur_addr_q;
            end
            if (!last) cur_addr_d = cur_addr_q + 18'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_addr_q <= '0;
         seed_q     <= '0;
         err_q      <= '0;
         first_q    <= '0;
         timeout_q  <= 1'b0;
         tcnt_q     <= '0;
         mem_q      <= 1'b0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         cur_addr_q <= cur_addr_d;
         seed_q     <= seed_d;
         err_q      <= err_d;
         first_q    <= first_d;
         timeout_q  <= timeout_d;
         tcnt_q     <= tcnt_d;
         mem_q      <= mem_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   assign busy           = (state_q != StIdle) && (state_q != StDone);
   assign done           = (state_q == StDone);
   assign pass           = done && (err_q == '0) && !timeout_q;
   assign timeout        = timeout_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;
   assign mem            = mem_q;
   assign rw             = rw_q;
   assign addr           = addr_q;
   assign data_f2s       = data_q;

endmodule

// File: tb/tb_sram_march_tester.sv
// Scoreboard bench for sram_march_tester: controller/SRAM stub with random latency and read
// corruption, expected transactions and results from a word-level model of the test.
module tb_sram_march_tester;
   localparam logic [17:0] LO  = 18'd0;
   localparam logic [17:0] HI  = 18'd7;
   localparam int          NW  = 8;
   localparam int unsigned TMO = 255;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] seed = '0;
   logic        ready = 1'b1;
   logic [15:0] data_s2f_r = '0;
   logic        busy, done, pass, timeout, mem, rw;
   logic [15:0] err_count, data_f2s;
   logic [17:0] first_err_addr, addr;

   sram_march_tester #(.ADDR_LO(LO), .ADDR_HI(HI), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .seed(seed), .busy(busy), .done(done),
      .pass(pass), .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
      .mem(mem), .rw(rw), .addr(addr), .data_f2s(data_f2s), .ready(ready),
      .data_s2f_r(data_s2f_r)
   );

   initial forever #5 clk = ~clk;

   typedef struct { logic rw; logic [17:0] a; logic [15:0] d; } txn_t;
   typedef struct { logic [15:0] err; logic [17:0] first; logic tmo; } res_t;

   txn_t        exp_txn[$];
   res_t        exp_res[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          mem_cyc = 0;
   logic [15:0] sram[NW];
   logic [15:0] corr[NW];
   bit          stall = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Word idx of the window, counted from LO, as defined by the pattern rule.
   function automatic logic [15:0] pat(input int idx, input logic [15:0] s);
`ifdef SRAM_TEST_LFSR_EN
      logic [15:0] v;
      v = (s == 16'h0) ? 16'hACE1 : s;
      for (int i = 0; i < idx; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
      return v;
`else
      logic [17:0] a;
      a = LO + 18'(idx);
      return a[15:0] ^ s;
`endif
   endfunction

   // Controller stub: drops ready on a request, completes after a random latency.
   initial begin : ctrl
      int          cnt;
      logic        p_rw;
      logic [17:0] p_a;
      logic [15:0] p_d;
      cnt = 0;
      p_rw = 1'b0;
      p_a = '0;
      p_d = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            ready = 1'b1;
            cnt = 0;
         end else if (mem) begin
            check("mem_while_ready", 32'(ready), 32'd1);
            p_rw = rw;
            p_a = addr;
            p_d = data_f2s;
            ready = 1'b0;
            cnt = stall ? 300 : int'($urandom_range(1, 4));
         end else if (!ready) begin
            cnt--;
            if (cnt == 0) begin
               if (p_rw) data_s2f_r = sram[p_a[2:0]] ^ corr[p_a[2:0]];
               else      sram[p_a[2:0]] = p_d;
               ready = 1'b1;
            end
         end
      end
   end

   initial begin : mon
      logic done_prev;
      txn_t t;
      res_t r;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (mem) begin
            mem_cyc = cyc;
            if (exp_txn.size() == 0) begin
               fail_now($sformatf("unexpected_mem addr=%0h rw=%0b", addr, rw));
            end else begin
               t = exp_txn.pop_front();
               check("txn_rw", 32'(rw), 32'(t.rw));
               check("txn_addr", 32'(addr), 32'(t.a));
               if (!t.rw) check("txn_wdata", 32'(data_f2s), 32'(t.d));
            end
         end
         if (done && !done_prev) begin
            if (exp_res.size() == 0) begin
               fail_now("unexpected_done");
            end else begin
               r = exp_res.pop_front();
               check("err_count", 32'(err_count), 32'(r.err));
               check("first_err_addr", 32'(first_err_addr), 32'(r.first));
               check("timeout", 32'(timeout), 32'(r.tmo));
               check("pass", 32'(pass), 32'(r.err == 0 && !r.tmo));
               check("busy_at_done", 32'(busy), 32'd0);
               if (r.tmo) check("timeout_latency", 32'(cyc - mem_cyc), 32'(TMO));
            end
         end
         done_prev = done;
      end
   end

   task automatic expect_run(input logic [15:0] s, input bit do_stall);
      txn_t t;
      res_t r;
      r.err = '0;
      r.first = '0;
      r.tmo = do_stall;
      for (int i = 0; i < (do_stall ? 1 : NW); i++) begin
         t.rw = 1'b0;
         t.a = LO + 18'(i);
         t.d = pat(i, s);
         exp_txn.push_back(t);
      end
      if (!do_stall) begin
         for (int i = 0; i < NW; i++) begin
            t.rw = 1'b1;
            t.a = LO + 18'(i);
            t.d = '0;
            exp_txn.push_back(t);
            if (corr[i] != 16'h0) begin
               if (r.err == 16'h0) r.first = LO + 18'(i);
               r.err++;
            end
         end
      end
      exp_res.push_back(r);
   endtask

   task automatic launch(input logic [15:0] s);
      @(negedge clk);
      seed = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("done_after_start", 32'(done), 32'd0);
      @(negedge clk);
      check("start_to_mem", 32'(mem), 32'd1);
   endtask

   task automatic wait_ready_idle();
      int k;
      k = 0;
      while (!ready && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (!ready) fail_now("ready_never_returned");
   endtask

   task automatic run(input logic [15:0] s, input bit do_stall, input bit poke);
      int k;
      bit poked;
      stall = do_stall;
      expect_run(s, do_stall);
      launch(s);
      k = 0;
      poked = 1'b0;
      while (!done && k < 3000) begin
         @(negedge clk);
         k++;
         if (start) start = 1'b0;
         else if (poke && !poked && mem && rw) begin
            start = 1'b1;
            poked = 1'b1;
         end
      end
      start = 1'b0;
      if (!done) fail_now("done_never_seen");
      @(negedge clk);
      check("txn_leftover", 32'(exp_txn.size()), 32'd0);
      exp_txn.delete();
      exp_res.delete();
      stall = 1'b0;
      wait_ready_idle();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_mem"}, 32'(mem), 32'd0);
      check({tag, "_rw"}, 32'(rw), 32'd0);
      check({tag, "_addr"}, 32'(addr), 32'd0);
      check({tag, "_data_f2s"}, 32'(data_f2s), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_timeout"}, 32'(timeout), 32'd0);
      check({tag, "_err_count"}, 32'(err_count), 32'd0);
      check({tag, "_first_err"}, 32'(first_err_addr), 32'd0);
   endtask

   task automatic reset_mid_read(input logic [15:0] s);
      int k;
      expect_run(s, 1'b0);
      launch(s);
      k = 0;
      while (!(mem && rw) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (!(mem && rw)) fail_now("read_never_issued");
      #1 reset = 1'b0;
      #1 check_zero("midreset");
      exp_txn.delete();
      exp_res.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic clear_corr();
      for (int i = 0; i < NW; i++) corr[i] = '0;
   endtask

   initial begin
      for (int i = 0; i < NW; i++) sram[i] = '0;
      clear_corr();
      repeat (3) @(negedge clk);
      check_zero("por");
      reset = 1'b1;
      @(negedge clk);
      check_zero("idle");

      run(16'h0000, 1'b0, 1'b0);
      corr[1] = 16'h0001;
      run(16'h0000, 1'b0, 1'b0);
      clear_corr();
      run(16'hBEEF, 1'b0, 1'b1);
      run(16'h1234, 1'b1, 1'b0);
      reset_mid_read(16'h5555);
      run(16'h5555, 1'b0, 1'b0);
      corr[7] = 16'h8000;
      corr[3] = 16'h0F00;
      run(16'h0000, 1'b0, 1'b0);

      for (int n = 0; n < 10; n++) begin
         int m;
         clear_corr();
         m = int'($urandom_range(0, 3));
         for (int j = 0; j < m; j++) begin
            corr[$urandom_range(0, NW - 1)] = 16'($urandom_range(1, 16'hFFFF));
         end
         run(16'($urandom), 1'b0, (n % 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
